// File: rtl/ooo_read_responder.sv
// AXI-style read slave model. Accepts 4-bit-ID read requests into a small
// slot pool and answers each one after a fixed or LFSR-randomised delay.
// Responses for different IDs may come back out of order, while responses
// that share an ID always return in request order. Each beat's data is
// {per-ID request number, ID}, so a checker can tell exactly which request
// produced it.
module ooo_read_responder #(
    parameter int         DATA_WIDTH = 8,
    parameter int         DEPTH      = 8,
    parameter int         MIN_LAT    = 2,
    parameter int         LAT_BITS   = 3,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            s_arid_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [3:0]            s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    input  logic                  cfg_random_i,
    output logic [4:0]            outstanding_o
);

    localparam int CNT_W = DATA_WIDTH - 4;

    // Slot pool
    logic [DEPTH-1:0]      r_valid;
    logic [3:0]            r_id    [DEPTH];
    logic [DATA_WIDTH-1:0] r_data  [DEPTH];
    logic [4:0]            r_timer [DEPTH];
    logic [3:0]            r_older [DEPTH];

    // Per-ID request counters, latency LFSR, R output register
    logic [CNT_W-1:0]      r_cnt [16];
    logic [7:0]            r_lfsr;
    logic                  r_rvalid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [3:0]            r_rid;

    logic [DEPTH-1:0]      w_elig;
    logic [DEPTH-1:0]      w_alloc_oh;
    logic [DEPTH-1:0]      w_ret_oh;
    logic                  w_accept;
    logic                  w_load;
    logic [3:0]            w_ret_id;
    logic [DATA_WIDTH-1:0] w_ret_data;
    logic [4:0]            w_same_cnt;
    logic [4:0]            w_count;
    logic [4:0]            w_timer_init;
    logic [LAT_BITS-1:0]   w_extra;
    logic                  w_lfsr_fb;

    // A slot may answer once its delay has elapsed and no older same-ID
    // request is still waiting ahead of it.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_elig
        assign w_elig[gi] = r_valid[gi] && (r_timer[gi] == 5'd0) && (r_older[gi] == 4'd0);
    end

    // arready looks only at registered valid bits, so a slot freed this
    // cycle becomes usable one cycle later.
    assign s_arready_o   = ~&r_valid;
    assign w_accept      = s_arvalid_i && s_arready_o;
    assign w_load        = (!r_rvalid || s_rready_i) && (|w_elig);
    assign w_extra       = cfg_random_i ? r_lfsr[LAT_BITS-1:0] : '0;
    assign w_timer_init  = 5'(MIN_LAT) + 5'(w_extra);
    assign w_lfsr_fb     = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
    assign outstanding_o = w_count;
    assign s_rvalid_o    = r_rvalid;
    assign s_rdata_o     = r_rdata;
    assign s_rid_o       = r_rid;

    // Pick the lowest free slot, the lowest eligible slot, and count slots.
    always_comb begin
        logic found_free;
        logic found_elig;
        found_free = 1'b0;
        found_elig = 1'b0;
        w_alloc_oh = '0;
        w_ret_oh   = '0;
        w_ret_id   = '0;
        w_ret_data = '0;
        w_same_cnt = '0;
        w_count    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!r_valid[i] && !found_free) begin
                w_alloc_oh[i] = 1'b1;
                found_free    = 1'b1;
            end
            if (w_elig[i] && w_load && !found_elig) begin
                w_ret_oh[i] = 1'b1;
                w_ret_id    = r_id[i];
                w_ret_data  = r_data[i];
                found_elig  = 1'b1;
            end
        end
        // The retiring slot is excluded so a same-cycle accept of the same ID
        // does not wait behind a request that is leaving now.
        for (int i = 0; i < DEPTH; i++) begin
            w_count = w_count + {4'd0, r_valid[i]};
            if (r_valid[i] && !w_ret_oh[i] && (r_id[i] == s_arid_i))
                w_same_cnt = w_same_cnt + 5'd1;
        end
    end

    // Slot state: allocate, retire, count down, and release same-ID followers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_id[i]    <= '0;
                r_data[i]  <= '0;
                r_timer[i] <= '0;
                r_older[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_accept && w_alloc_oh[i]) begin
                    r_valid[i] <= 1'b1;
                    r_id[i]    <= s_arid_i;
                    r_data[i]  <= {r_cnt[s_arid_i], s_arid_i};
                    r_timer[i] <= w_timer_init;
                    r_older[i] <= w_same_cnt[3:0];
                end else begin
                    if (w_ret_oh[i])
                        r_valid[i] <= 1'b0;
                    if (r_timer[i] != 5'd0)
                        r_timer[i] <= r_timer[i] - 5'd1;
                    if (w_load && r_valid[i] && !w_ret_oh[i] &&
                        (r_id[i] == w_ret_id) && (r_older[i] != 4'd0))
                        r_older[i] <= r_older[i] - 4'd1;
                end
            end
        end
    end

    // Per-ID request numbering and LFSR stepping, both on AR handshakes only.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++)
                r_cnt[i] <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (w_accept) begin
            r_cnt[s_arid_i] <= r_cnt[s_arid_i] + CNT_W'(1);
            r_lfsr          <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    // R output register: load a new beat when free or being drained, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rid    <= '0;
        end else if (w_load) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ret_data;
            r_rid    <= w_ret_id;
        end else if (s_rready_i) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule
